// File: rtl/dds_wave_pkg.sv
// dds_wave_pkg: waveform select codes, FSM encoding and level helpers for dds_wave_gen.
// Rev 1.0
`default_nettype none

package dds_wave_pkg;

   localparam logic [2:0] WAVE_SAW    = 3'd0;
   localparam logic [2:0] WAVE_TRI    = 3'd1;
   localparam logic [2:0] WAVE_SQUARE = 3'd2;
   localparam logic [2:0] WAVE_SINE   = 3'd3;
   localparam logic [2:0] WAVE_FULL   = 3'd4;
   localparam logic [2:0] WAVE_HALF   = 3'd5;

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   function automatic int unsigned wave_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

   function automatic int unsigned wave_mid(input int unsigned w);
      return 32'd1 << (w - 32'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sine_lut_quarter.sv
// sine_lut_quarter: quarter-wave sine ROM with mirroring, offset-binary output, 1-cycle latency.
// Rev 1.0
`default_nettype none

module sine_lut_quarter
   import dds_wave_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] addr,
   output logic [DATA_W-1:0] sample
);

   localparam int Q = 2 ** (DATA_W - 2);
   localparam logic [DATA_W-1:0] MID = DATA_W'(wave_mid(DATA_W));

   // Bhaskara sine approximation sampled at half-step offsets so the quarter mirrors exactly.
   function automatic logic [DATA_W-2:0] quarter_val(input int i);
      longint amp_l, n, a, ab, num, den;
      amp_l = longint'(wave_mid(DATA_W)) - 64'sd1;
      n     = 64'sd4 * longint'(Q);
      a     = 64'sd2 * longint'(i) + 64'sd1;
      ab    = a * (n - a);
      num   = 64'sd32 * amp_l * ab;
      den   = 64'sd5 * n * n - 64'sd4 * ab;
      return (DATA_W-1)'((num + den) / (64'sd2 * den));
   endfunction

   logic [DATA_W-2:0] rom [Q];

   generate
      for (genvar gi = 0; gi < Q; gi++) begin : g_rom
         assign rom[gi] = quarter_val(gi);
      end
   endgenerate

   logic [1:0]        quad;
   logic [DATA_W-3:0] idx;
   logic [DATA_W-3:0] ridx;
   logic [DATA_W-2:0] mag;
   logic [DATA_W-1:0] value;

   always_comb begin
      quad  = addr[DATA_W-1 -: 2];
      idx   = addr[DATA_W-3:0];
      ridx  = quad[0] ? ~idx : idx;
      mag   = rom[ridx];
      value = quad[1] ? (MID - {1'b0, mag}) : (MID + {1'b0, mag});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sample <= '0;
      end else if (en) begin
         sample <= value;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dds_wave_gen.sv
// dds_wave_gen: phase-accumulator multi-waveform generator with wrap-synchronous config updates.
// Rev 1.0
`default_nettype none

module dds_wave_gen
   import dds_wave_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int PHASE_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [2:0]         cfg_sel,
   input  logic [PHASE_W-1:0] cfg_ftw,
   input  logic [DATA_W-1:0]  cfg_duty,
   input  logic [DATA_W-1:0]  cfg_amp,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_signal,
   output logic               wrap
);

   localparam logic [DATA_W-1:0] MAX = DATA_W'(wave_max(DATA_W));
   localparam logic [DATA_W-1:0] MID = DATA_W'(wave_mid(DATA_W));

   state_t state, next_state;

   logic [PHASE_W-1:0] ftw_act, ftw_sh;
   logic [2:0]         sel_act, sel_sh;
   logic [DATA_W-1:0]  duty_act, duty_sh;
   logic [DATA_W-1:0]  amp_act, amp_sh;

   logic [PHASE_W-1:0] phase;
   logic [PHASE_W:0]   phase_sum;
   logic               carry, carry_d;
   logic               xfer, load_direct, load_shadow, apply_shadow;

   assign phase_sum = {1'b0, phase} + {1'b0, ftw_act};
   assign carry     = en && phase_sum[PHASE_W];
   assign cfg_ready = (state != ST_PEND);
   assign xfer      = cfg_valid && cfg_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_STOP;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state   = state;
      load_direct  = 1'b0;
      load_shadow  = 1'b0;
      apply_shadow = 1'b0;
      if (!en) begin
         next_state = ST_STOP;
         if (state == ST_PEND) begin
            apply_shadow = 1'b1;
         end else if (xfer) begin
            load_direct = 1'b1;
         end
      end else begin
         case (state)
            ST_STOP: begin
               next_state = ST_RUN;
               if (xfer) begin
                  load_direct = 1'b1;
               end
            end
            ST_RUN: begin
               if (xfer) begin
                  next_state  = ST_PEND;
                  load_shadow = 1'b1;
               end
            end
            ST_PEND: begin
               if (carry) begin
                  next_state   = ST_RUN;
                  apply_shadow = 1'b1;
               end
            end
            default: next_state = ST_STOP;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ftw_act  <= '0;
         sel_act  <= '0;
         duty_act <= '0;
         amp_act  <= '0;
         ftw_sh   <= '0;
         sel_sh   <= '0;
         duty_sh  <= '0;
         amp_sh   <= '0;
      end else begin
         if (load_direct) begin
            ftw_act  <= cfg_ftw;
            sel_act  <= cfg_sel;
            duty_act <= cfg_duty;
            amp_act  <= cfg_amp;
         end else if (apply_shadow) begin
            ftw_act  <= ftw_sh;
            sel_act  <= sel_sh;
            duty_act <= duty_sh;
            amp_act  <= amp_sh;
         end
         if (load_shadow) begin
            ftw_sh  <= cfg_ftw;
            sel_sh  <= cfg_sel;
            duty_sh <= cfg_duty;
            amp_sh  <= cfg_amp;
         end
      end
   end

   // carry_d flags that the phase now held is the first one after a wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase   <= '0;
         carry_d <= 1'b0;
      end else if (en) begin
         phase   <= phase_sum[PHASE_W-1:0];
         carry_d <= phase_sum[PHASE_W];
      end
   end

   // Each sample carries the config it was generated with, so a swap never tears a sample.
   logic              v0, v1;
   logic [DATA_W-1:0] s0_p, s0_duty, s0_amp;
   logic [2:0]        s0_sel;
   logic              s0_wrap;
   logic [DATA_W-1:0] s1_shape, s1_amp;
   logic [2:0]        s1_sel;
   logic              s1_wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         v0      <= 1'b0;
         s0_p    <= '0;
         s0_sel  <= '0;
         s0_duty <= '0;
         s0_amp  <= '0;
         s0_wrap <= 1'b0;
      end else begin
         v0 <= en;
         if (en) begin
            s0_p    <= phase[PHASE_W-1 -: DATA_W];
            s0_sel  <= sel_act;
            s0_duty <= duty_act;
            s0_amp  <= amp_act;
            s0_wrap <= carry_d;
         end
      end
   end

   logic [DATA_W-1:0] tri_dbl, shape_s0;

   always_comb begin
      shape_s0 = '0;
      tri_dbl  = {s0_p[DATA_W-2:0], 1'b0};
      case (s0_sel)
         WAVE_SAW:    shape_s0 = s0_p;
         WAVE_TRI:    shape_s0 = s0_p[DATA_W-1] ? ~tri_dbl : tri_dbl;
         WAVE_SQUARE: shape_s0 = (s0_p < s0_duty) ? MAX : '0;
         default:     shape_s0 = '0;
      endcase
   end

   logic [DATA_W-1:0] lut_q;

   sine_lut_quarter #(
      .DATA_W (DATA_W)
   ) u_sine (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .addr   (s0_p),
      .sample (lut_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         v1       <= 1'b0;
         s1_shape <= '0;
         s1_sel   <= '0;
         s1_amp   <= '0;
         s1_wrap  <= 1'b0;
      end else begin
         v1 <= en && v0;
         if (en) begin
            s1_shape <= shape_s0;
            s1_sel   <= s0_sel;
            s1_amp   <= s0_amp;
            s1_wrap  <= s0_wrap;
         end
      end
   end

   logic [DATA_W-1:0]   shape_s1, scaled;
   logic [DATA_W:0]     amp_p1;
   logic [2*DATA_W:0]   product;

   always_comb begin
      shape_s1 = s1_shape;
      case (s1_sel)
         WAVE_SINE: shape_s1 = lut_q;
         WAVE_FULL: shape_s1 = (lut_q < MID) ? (MAX - lut_q) : lut_q;
         WAVE_HALF: shape_s1 = (lut_q < MID) ? MID : lut_q;
         default:   shape_s1 = s1_shape;
      endcase
      amp_p1  = {1'b0, s1_amp} + (DATA_W+1)'(1);
      product = {{(DATA_W+1){1'b0}}, shape_s1} * {{DATA_W{1'b0}}, amp_p1};
      scaled  = DATA_W'(product >> DATA_W);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_signal <= '0;
         wrap       <= 1'b0;
      end else begin
         out_valid <= en && v1;
         wrap      <= en && v1 && s1_wrap;
         if (en && v1) begin
            out_signal <= scaled;
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/dds_wave_gen.md
Name: dds_wave_gen

Overview:
- Parametrised, phase-accumulator (DDS) multi-waveform generator.
- Programmable frequency, duty cycle and amplitude.
- Glitch-free configuration updates via a valid/ready handshake; updates take effect on phase wrap.
- Sits between the lab control logic (switches/registers) and the DAC/PWM output stage.

Parameters:
- DATA_W, 8, output sample width; also the sine LUT address width.
- PHASE_W, 16, phase accumulator width; must be >= DATA_W.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  run enable; phase advances only while high
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  configuration can be accepted
- cfg_sel  in  3  waveform select: 0 saw, 1 triangle, 2 square, 3 sine, 4 full-wave, 5 half-wave; 6 and 7 give 0
- cfg_ftw  in  PHASE_W  frequency tuning word (phase increment)
- cfg_duty  in  DATA_W  square threshold
- cfg_amp  in  DATA_W  amplitude scale
- out_valid  out  1  out_signal holds a valid sample
- out_signal  out  DATA_W  waveform sample, unsigned offset-binary
- wrap  out  1  one-cycle pulse marking the sample generated from the first wrapped phase

Behaviour:
- Reset, synchronous active-high, clk and rst only:
  - phase, active config, shadow config, pipeline and FSM cleared.
  - out_signal=0, out_valid=0, wrap=0, cfg_ready=1.
  - Reset mid-operation discards any pending config.
- FSM states and transitions:
  - STOP: en=0.
  - RUN: en=1, no pending config.
  - PEND: en=1, shadow config waiting.
  - STOP->RUN on en=1.
  - RUN->PEND on a cfg handshake.
  - PEND->RUN on phase carry.
  - Any state->STOP on en=0.
  - In STOP, a handshake loads the active config directly on the next edge.
  - If a config is pending when en falls, it is applied on entering STOP.
- Handshake:
  - Transfer when cfg_valid && cfg_ready.
  - cfg_ready = (state != PEND).
  - Inputs are sampled only on a transfer.
- Phase: P <= P + ftw_active, mod 2^PHASE_W, while en=1. The carry cycle is the cycle whose increment overflows.
- Config swap: on the carry cycle in PEND, the active config takes the shadow contents.
  - The new ftw is used from the next increment.
  - The new sel, duty and amp apply to the sample generated from the wrapped phase.
  - A handshake in the same cycle as a RUN-state carry is applied at the following wrap.
- Pipeline, 3 stages:
  - S0: phase register.
  - S1: shape, including the registered sine LUT.
  - S2: amplitude scale into out_signal.
  - out_valid rises on the 3rd edge after en rises.
  - When en=0: out_valid=0, out_signal holds its last value, phase holds.
  - wrap is delayed to align with its sample.
- Shapes, with p = P[PHASE_W-1 -: DATA_W], MAX = 2^DATA_W-1, MID = 2^(DATA_W-1):
  - saw = p.
  - tri = p[msb] ? ~(p<<1) : (p<<1), in DATA_W bits.
  - square = (p < duty) ? MAX : 0. duty=0 gives constant 0.
  - sine = LUT(p), offset-binary around MID.
  - full-wave = (s < MID) ? MAX - s : s.
  - half-wave = (s < MID) ? MID : s.
- Amplitude: out = (shape * (amp+1)) >> DATA_W.
  - amp=MAX is exact passthrough.
  - amp=0 gives 0.
  - The product is held at 2*DATA_W+1 bits before the shift.

Decomposition:
- Package dds_wave_pkg holds:
  - waveform select constants (WAVE_SAW..WAVE_HALF)
  - FSM state encoding (ST_STOP, ST_RUN, ST_PEND)
  - a function for MID/MAX from DATA_W
- Sub-module sine_lut_quarter:
  - quarter-wave ROM with 2^(DATA_W-2) entries
  - mirroring and inversion logic
  - 1-cycle registered output
  - parameter DATA_W

Test Plan:
1. Reset: rst=1 for 2 cycles mid-run -> out_signal=0, out_valid=0, wrap=0, cfg_ready=1; phase restarts at 0 after release.
2. Saw: DATA_W=8, PHASE_W=16, ftw=0x0100, amp=0xFF, en=1 -> out_valid=1 at 3rd edge; out_signal=0,1,…,255,0; wrap high with each 0 after the first period.
3. Triangle: ftw=0x0100 -> p=127 gives 254, p=128 gives 255, p=255 gives 1.
4. Square: duty=0x40, ftw=0x0400 -> period of 64 samples, 16 samples at 0xFF then 48 at 0x00.
5. Deferred config: saw running, handshake sel=2 at p=100 -> cfg_ready=0; saw continues to 255; square starts at the wrap sample; cfg_ready=1 the cycle after the carry. Also handshake in the carry cycle -> applied one period later.
6. Amplitude and rectify: saw, amp=0x7F, p=200 -> 100. Full-wave with sine sample 0x40 -> 0xBF. Half-wave with sine sample 0x40 -> 0x80. sel=7 -> 0.
